// File: rtl/prime_pkg.sv
// Shared constants and FSM encoding for the prime number ASCII formatter.
package prime_pkg;

    localparam int         VAL_W       = 8;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] SEP_DEFAULT = 8'h20;
    localparam logic [7:0] EOL_DEFAULT = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DIV100   = 4'd1,
        ST_DIV10    = 4'd2,
        ST_EMIT_H   = 4'd3,
        ST_EMIT_T   = 4'd4,
        ST_EMIT_O   = 4'd5,
        ST_EMIT_SEP = 4'd6,
        ST_EMIT_EOL = 4'd7,
        ST_FIN      = 4'd8
    } fmt_state_t;

    // True for every state that presents a byte on the output interface.
    function automatic logic is_emit(input fmt_state_t s);
        return (s inside {ST_EMIT_H, ST_EMIT_T, ST_EMIT_O, ST_EMIT_SEP, ST_EMIT_EOL});
    endfunction

endpackage

// File: rtl/prime_fifo.sv
// Synchronous FIFO holding prime values between the sieve strobe and the formatter.
module prime_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/prime_formatter.sv
// Buffers sieve primes and streams them as decimal ASCII with separators and a final EOL.
// Output handshake: a byte transfers on a rising clk edge where out_valid && out_ready.
module prime_formatter
    import prime_pkg::*;
#(
    parameter int         DEPTH = 8,
    parameter logic [7:0] SEP   = SEP_DEFAULT,
    parameter logic [7:0] EOL   = EOL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_rdy,
    input  logic [VAL_W-1:0] in_dout,
    input  logic             in_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_done,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    fmt_state_t       r_state;
    fmt_state_t       w_state_nxt;
    logic [VAL_W-1:0] r_work;
    logic [VAL_W-1:0] w_work_nxt;
    logic [1:0]       r_h;
    logic [1:0]       w_h_nxt;
    logic [3:0]       r_t;
    logic [3:0]       w_t_nxt;
    logic             r_done_seen;
    logic             r_overflow;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_done;
    logic [7:0]       w_byte_nxt;

    logic             w_push_req;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic [VAL_W-1:0] w_head;
    logic             w_hs;

    // Strobes arriving once the sieve has reported completion are ignored entirely.
    assign w_push_req = in_rdy && !r_done_seen;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    assign w_hs       = r_out_valid && out_ready;

    prime_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (VAL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_din   (in_dout),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_h_nxt     = r_h;
        w_t_nxt     = r_t;
        case (r_state)
            ST_IDLE: begin
                if (w_count != '0) begin
                    w_work_nxt  = w_head;
                    w_h_nxt     = 2'd0;
                    w_t_nxt     = 4'd0;
                    w_state_nxt = ST_DIV100;
                end else if (r_done_seen) begin
                    w_state_nxt = ST_EMIT_EOL;
                end
            end
            ST_DIV100: begin
                if (r_work >= 8'd100) begin
                    w_work_nxt = r_work - 8'd100;
                    w_h_nxt    = r_h + 2'd1;
                end else begin
                    w_state_nxt = ST_DIV10;
                end
            end
            ST_DIV10: begin
                if (r_work >= 8'd10) begin
                    w_work_nxt = r_work - 8'd10;
                    w_t_nxt    = r_t + 4'd1;
                end else if (r_h != 2'd0) begin
                    w_state_nxt = ST_EMIT_H;
                end else if (r_t != 4'd0) begin
                    w_state_nxt = ST_EMIT_T;
                end else begin
                    w_state_nxt = ST_EMIT_O;
                end
            end
            ST_EMIT_H:   if (w_hs) w_state_nxt = ST_EMIT_T;
            ST_EMIT_T:   if (w_hs) w_state_nxt = ST_EMIT_O;
            ST_EMIT_O:   if (w_hs) w_state_nxt = ST_EMIT_SEP;
            ST_EMIT_SEP: if (w_hs) w_state_nxt = ST_IDLE;
            ST_EMIT_EOL: if (w_hs) w_state_nxt = ST_FIN;
            ST_FIN:      w_state_nxt = ST_FIN;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // The output byte is registered from the next state, so it is stable while stalled.
    always_comb begin
        w_byte_nxt = 8'h00;
        case (w_state_nxt)
            ST_EMIT_H:   w_byte_nxt = ASCII_ZERO + {6'd0, w_h_nxt};
            ST_EMIT_T:   w_byte_nxt = ASCII_ZERO + {4'd0, w_t_nxt};
            ST_EMIT_O:   w_byte_nxt = ASCII_ZERO + w_work_nxt;
            ST_EMIT_SEP: w_byte_nxt = SEP;
            ST_EMIT_EOL: w_byte_nxt = EOL;
            default:     w_byte_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_h         <= '0;
            r_t         <= '0;
            r_done_seen <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_work      <= w_work_nxt;
            r_h         <= w_h_nxt;
            r_t         <= w_t_nxt;
            r_out_valid <= is_emit(w_state_nxt);
            r_out_data  <= w_byte_nxt;
            r_out_done  <= (w_state_nxt == ST_FIN);
            if (in_done) begin
                r_done_seen <= 1'b1;
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_done  = r_out_done;
    assign overflow  = r_overflow;

endmodule
